mvp_vertex_transform: RTL

- Consumer of the 4x4 Q8.8 MVP matrix produced by get_mvp_matrix.
- Latches the matrix, accepts object-space vertices over a valid/ready handshake and computes clip-space (x,y,z,w) = MVP * (x,y,z,1).
- Evaluates one matrix row per cycle and delivers results to the downstream rasterizer/viewport stage over valid/ready.

---
 rtl/gfx_fixed_pkg.sv | 35 +++
 rtl/fix_dot4.sv | 79 +++++++
 rtl/mvp_vertex_transform.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/gfx_fixed_pkg.sv
// ============================================================================
// | Module      : gfx_fixed_pkg                                              |
// | Description : Shared fixed-point types, defaults and the vertex          |
// |               transform state encoding for the graphics pipeline.        |
// | Contents    : DW_DEF / FRAC_DEF   default width / fractional bits        |
// |               fix_t, mat4_t, vec4_t  signed Q-format containers          |
// |               FIX_ONE               1.0 in the default Q format          |
// |               state_t               transform sequencer states           |
// | Revision    : 1.0  initial release                                       |
// ============================================================================
`default_nettype none

package gfx_fixed_pkg;

  localparam int DW_DEF   = 16;
  localparam int FRAC_DEF = 8;

  typedef logic signed [DW_DEF-1:0] fix_t;
  typedef fix_t [15:0]              mat4_t;   // row-major, element 4*r+c
  typedef fix_t [3:0]               vec4_t;

  localparam fix_t FIX_ONE = fix_t'(1 << FRAC_DEF);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ROW0 = 3'd1,
    ST_ROW1 = 3'd2,
    ST_ROW2 = 3'd3,
    ST_ROW3 = 3'd4,
    ST_HOLD = 3'd5
  } state_t;

endpackage : gfx_fixed_pkg

`default_nettype wire

// File: rtl/fix_dot4.sv
// ============================================================================
// | Module      : fix_dot4                                                   |
// | Description : Combinational fixed-point row evaluation                   |
// |               res = round(a0*x + a1*y + a2*z + a3*1.0) narrowed to DW.   |
// | Ports       : a0..a3  in  DW  signed matrix row elements                 |
// |               x,y,z   in  DW  signed vertex coordinates (w = 1.0)        |
// |               res     out DW  signed rounded, narrowed result            |
// | Options     : MVP_SATURATE_EN  defined   -> clamp to DW signed range     |
// |                                undefined -> two's-complement wrap        |
// | Revision    : 1.0  initial release                                       |
// ============================================================================
`default_nettype none

module fix_dot4
  import gfx_fixed_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic signed [DW-1:0] a0,
  input  logic signed [DW-1:0] a1,
  input  logic signed [DW-1:0] a2,
  input  logic signed [DW-1:0] a3,
  input  logic signed [DW-1:0] x,
  input  logic signed [DW-1:0] y,
  input  logic signed [DW-1:0] z,
  output logic signed [DW-1:0] res
);

  localparam int PW = 2 * DW;      // full product width
  localparam int SW = 2 * DW + 2;  // sum width: three products plus the w term

  logic signed [PW-1:0] w_p0;
  logic signed [PW-1:0] w_p1;
  logic signed [PW-1:0] w_p2;
  logic signed [SW-1:0] w_sum;
  logic signed [SW-1:0] w_rnd;
  logic signed [SW-1:0] w_shr;

  assign w_p0 = PW'(a0) * PW'(x);
  assign w_p1 = PW'(a1) * PW'(y);
  assign w_p2 = PW'(a2) * PW'(z);

  // w is implicitly 1.0, so the fourth term is the element moved up by FRAC.
  assign w_sum = SW'(w_p0) + SW'(w_p1) + SW'(w_p2) + (SW'(a3) <<< FRAC);

  // Round half up before the arithmetic shift back to the coordinate scale.
  generate
    if (FRAC > 0) begin : g_round
      assign w_rnd = w_sum + (SW'(1) <<< (FRAC - 1));
    end else begin : g_no_round
      assign w_rnd = w_sum;
    end
  endgenerate

  assign w_shr = w_rnd >>> FRAC;

`ifdef MVP_SATURATE_EN
  localparam logic signed [SW-1:0] MAX_V = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [SW-1:0] MIN_V = {{(SW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  always_comb begin
    res = w_shr[DW-1:0];
    if (w_shr > MAX_V) begin
      res = MAX_V[DW-1:0];
    end else if (w_shr < MIN_V) begin
      res = MIN_V[DW-1:0];
    end
  end
`else
  // Wrap build keeps only the low DW bits; the upper bits are intentionally dropped.
  logic w_unused_hi;
  assign w_unused_hi = ^w_shr[SW-1:DW];
  assign res         = w_shr[DW-1:0];
`endif

endmodule : fix_dot4

`default_nettype wire

// File: rtl/mvp_vertex_transform.sv
// ============================================================================
// | Module      : mvp_vertex_transform                                       |
// | Description : Latches a 4x4 Q-format MVP matrix and transforms object-   |
// |               space vertices (x,y,z,1) to clip space, one matrix row     |
// |               per cycle through a single shared fix_dot4.                |
// | Ports       : Clk, Reset_n            clock / async active-low reset     |
// |               mvp_i, mvp_load         matrix input and capture pulse     |
// |               vin_valid/ready, vin_x/y/z   vertex input handshake        |
// |               vout_valid/ready, vout_x/y/z/w  clip-space result          |
// |               busy                    high whenever not IDLE             |
// | Options     : MVP_SATURATE_EN (inside fix_dot4) selects clamp vs wrap    |
// | Revision    : 1.0  initial release                                       |
// ============================================================================
`default_nettype none

module mvp_vertex_transform
  import gfx_fixed_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic [15:0][DW-1:0] mvp_i,
  input  logic                mvp_load,
  input  logic                vin_valid,
  output logic                vin_ready,
  input  logic [DW-1:0]       vin_x,
  input  logic [DW-1:0]       vin_y,
  input  logic [DW-1:0]       vin_z,
  output logic                vout_valid,
  input  logic                vout_ready,
  output logic [DW-1:0]       vout_x,
  output logic [DW-1:0]       vout_y,
  output logic [DW-1:0]       vout_z,
  output logic [DW-1:0]       vout_w,
  output logic                busy
);

  state_t               state_q, state_d;
  logic [15:0][DW-1:0]  mat_q, mat_d;
  logic [15:0][DW-1:0]  shadow_q, shadow_d;
  logic                 load_pending_q, load_pending_d;
  logic [DW-1:0]        x_q, x_d;
  logic [DW-1:0]        y_q, y_d;
  logic [DW-1:0]        z_q, z_d;
  logic [3:0][DW-1:0]   res_q, res_d;      // lane 0..3 = x,y,z,w
  logic                 vout_valid_q, vout_valid_d;

  logic [1:0]           w_row;
  logic [DW-1:0]        w_dot;

  // Row currently being evaluated; only meaningful in the ROW states.
  always_comb begin
    w_row = 2'd0;
    case (state_q)
      ST_ROW1: w_row = 2'd1;
      ST_ROW2: w_row = 2'd2;
      ST_ROW3: w_row = 2'd3;
      default: w_row = 2'd0;
    endcase
  end

  fix_dot4 #(
    .DW   (DW),
    .FRAC (FRAC)
  ) u_dot4 (
    .a0  (mat_q[{w_row, 2'd0}]),
    .a1  (mat_q[{w_row, 2'd1}]),
    .a2  (mat_q[{w_row, 2'd2}]),
    .a3  (mat_q[{w_row, 2'd3}]),
    .x   (x_q),
    .y   (y_q),
    .z   (z_q),
    .res (w_dot)
  );

  always_comb begin
    state_d        = state_q;
    mat_d          = mat_q;
    shadow_d       = shadow_q;
    load_pending_d = load_pending_q;
    x_d            = x_q;
    y_d            = y_q;
    z_d            = z_q;
    res_d          = res_q;
    vout_valid_d   = vout_valid_q;

    // A load arriving mid-vertex is parked so the in-flight vertex sees one matrix.
    if (mvp_load && (state_q != ST_IDLE)) begin
      shadow_d       = mvp_i;
      load_pending_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        // The matrix is written first, so a vertex accepted together with a load uses it.
        if (mvp_load) begin
          mat_d = mvp_i;
        end
        if (vin_valid) begin
          x_d     = vin_x;
          y_d     = vin_y;
          z_d     = vin_z;
          state_d = ST_ROW0;
        end
      end
      ST_ROW0: begin
        res_d[0] = w_dot;
        state_d  = ST_ROW1;
      end
      ST_ROW1: begin
        res_d[1] = w_dot;
        state_d  = ST_ROW2;
      end
      ST_ROW2: begin
        res_d[2] = w_dot;
        state_d  = ST_ROW3;
      end
      ST_ROW3: begin
        res_d[3]     = w_dot;
        vout_valid_d = 1'b1;
        state_d      = ST_HOLD;
      end
      ST_HOLD: begin
        if (vout_ready) begin
          vout_valid_d   = 1'b0;
          state_d        = ST_IDLE;
          // Entering IDLE: a load on this very edge is the newest, otherwise the parked one.
          if (mvp_load) begin
            mat_d = mvp_i;
          end else if (load_pending_q) begin
            mat_d = shadow_q;
          end
          load_pending_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q        <= ST_IDLE;
      mat_q          <= '0;
      shadow_q       <= '0;
      load_pending_q <= 1'b0;
      x_q            <= '0;
      y_q            <= '0;
      z_q            <= '0;
      res_q          <= '0;
      vout_valid_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      mat_q          <= mat_d;
      shadow_q       <= shadow_d;
      load_pending_q <= load_pending_d;
      x_q            <= x_d;
      y_q            <= y_d;
      z_q            <= z_d;
      res_q          <= res_d;
      vout_valid_q   <= vout_valid_d;
    end
  end

  assign vin_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign vout_valid = vout_valid_q;
  assign vout_x     = res_q[0];
  assign vout_y     = res_q[1];
  assign vout_z     = res_q[2];
  assign vout_w     = res_q[3];

endmodule : mvp_vertex_transform

`default_nettype wire
